// File: rtl/instr_fetch.sv
// instr_fetch: consumer side of the 4-entry calculator instruction ring.
// Pops words from the ring, drops NOPs and illegal words, and holds each
// legal instruction on a valid/ready output stage until the execution unit
// accepts it. Also keeps a retired-instruction counter and a sticky
// illegal-instruction flag.
module instr_fetch #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [(32<<DEPTH_LOG2)-1:0]   queue,
    input  logic [DEPTH_LOG2-1:0]         write_head,
    output logic [DEPTH_LOG2-1:0]         read_head,
    output logic [DEPTH_LOG2:0]           queue_level,
    output logic                          op_valid,
    input  logic                          op_ready,
    output logic [3:0]                    op_code,
    output logic [3:0]                    reg_dst,
    output logic [3:0]                    reg_a,
    output logic [3:0]                    reg_b,
    output logic [15:0]                   imm,
    output logic [15:0]                   retired,
    output logic                          illegal
);

    // Opcode and must-be-zero check for one ring word.
    function automatic logic word_is_legal(input logic [31:0] w);
        logic ok;
        case (w[31:28])
            4'h0:                         ok = (w == 32'h0);
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: ok = (w[27:12] == 16'h0);
            4'h8, 4'h9, 4'hA, 4'hC:       ok = (w[27:4] == 24'h0);
            4'hB:                         ok = (w[11:4] == 8'h0);
            4'hD:                         ok = (w[27:0] == 28'h0);
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [DEPTH_LOG2-1:0] read_head_q, read_head_d;
    logic                  op_valid_q,  op_valid_d;
    logic [3:0]            op_code_q,   op_code_d;
    logic [3:0]            reg_dst_q,   reg_dst_d;
    logic [3:0]            reg_a_q,     reg_a_d;
    logic [3:0]            reg_b_q,     reg_b_d;
    logic [15:0]           imm_q,       imm_d;
    logic [15:0]           retired_q,   retired_d;
    logic                  illegal_q,   illegal_d;

    logic                  ring_empty;
    logic                  handshake;
    logic                  load;
    logic [31:0]           word;
    logic                  word_legal;
    logic                  word_nop;
    logic [DEPTH_LOG2-1:0] level_mod;

    // Head comparison, handshake and fetch decision, plus the word at read_head.
    always_comb begin
        ring_empty = (read_head_q == write_head);
        handshake  = op_valid_q && op_ready;
        load       = !ring_empty && (!op_valid_q || op_ready);
        word       = queue[{read_head_q, 5'd0} +: 32];
        word_legal = word_is_legal(word);
        word_nop   = (word == 32'h0);
        level_mod  = write_head - read_head_q;
    end

    // Next-state: pop on load, present legal non-NOP words, count handshakes.
    always_comb begin
        read_head_d = read_head_q;
        op_valid_d  = op_valid_q;
        op_code_d   = op_code_q;
        reg_dst_d   = reg_dst_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        imm_d       = imm_q;
        retired_d   = retired_q;
        illegal_d   = illegal_q;

        // A handshake empties the output stage unless a replacement loads below.
        if (handshake) begin
            op_valid_d = 1'b0;
            retired_d  = retired_q + 16'd1;
        end

        if (load) begin
            read_head_d = read_head_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            if (!word_legal) begin
                illegal_d = 1'b1;
            end else if (!word_nop) begin
                op_valid_d = 1'b1;
                op_code_d  = word[31:28];
                reg_dst_d  = word[3:0];
                reg_a_d    = word[7:4];
                reg_b_d    = word[11:8];
                imm_d      = word[27:12];
            end
        end
    end

    // State registers; reset discards any held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_head_q <= '0;
            op_valid_q  <= 1'b0;
            op_code_q   <= 4'h0;
            reg_dst_q   <= 4'h0;
            reg_a_q     <= 4'h0;
            reg_b_q     <= 4'h0;
            imm_q       <= 16'h0;
            retired_q   <= 16'h0;
            illegal_q   <= 1'b0;
        end else begin
            read_head_q <= read_head_d;
            op_valid_q  <= op_valid_d;
            op_code_q   <= op_code_d;
            reg_dst_q   <= reg_dst_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            imm_q       <= imm_d;
            retired_q   <= retired_d;
            illegal_q   <= illegal_d;
        end
    end

    assign read_head   = read_head_q;
    assign queue_level = {1'b0, level_mod};
    assign op_valid    = op_valid_q;
    assign op_code     = op_code_q;
    assign reg_dst     = reg_dst_q;
    assign reg_a       = reg_a_q;
    assign reg_b       = reg_b_q;
    assign imm         = imm_q;
    assign retired     = retired_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Table-driven bench for instr_fetch. The bench plays the ring writer:
// each vector optionally enqueues one word (entry and write_head change
// together), sets op_ready, advances one clock and checks every output.
module tb_instr_fetch;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] queue = '0;
    logic [1:0]   write_head = 2'd0;
    logic [1:0]   read_head;
    logic [2:0]   queue_level;
    logic         op_valid;
    logic         op_ready = 1'b0;
    logic [3:0]   op_code, reg_dst, reg_a, reg_b;
    logic [15:0]  imm, retired;
    logic         illegal;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.DEPTH_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n), .queue(queue), .write_head(write_head),
        .read_head(read_head), .queue_level(queue_level),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .reg_dst(reg_dst), .reg_a(reg_a), .reg_b(reg_b),
        .imm(imm), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        bit          enq;
        logic [31:0] word;
        bit          rdy;
        logic        vld;
        logic [3:0]  opc, dst, a, b;
        logic [15:0] imm;
        logic [1:0]  rh;
        logic [2:0]  lvl;
        logic [15:0] ret;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit do_rst, bit enq, logic [31:0] word, bit rdy,
                                logic vld, logic [3:0] opc, logic [3:0] dst,
                                logic [3:0] a, logic [3:0] b, logic [15:0] im,
                                logic [1:0] rh, logic [2:0] lvl,
                                logic [15:0] ret, logic ill);
        vec_t v;
        v.do_rst = do_rst; v.enq = enq; v.word = word; v.rdy = rdy;
        v.vld = vld; v.opc = opc; v.dst = dst; v.a = a; v.b = b; v.imm = im;
        v.rh = rh; v.lvl = lvl; v.ret = ret; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got 0x%0h, required 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("op_valid",    idx, 32'(op_valid),    32'(v.vld));
        check("op_code",     idx, 32'(op_code),     32'(v.opc));
        check("reg_dst",     idx, 32'(reg_dst),     32'(v.dst));
        check("reg_a",       idx, 32'(reg_a),       32'(v.a));
        check("reg_b",       idx, 32'(reg_b),       32'(v.b));
        check("imm",         idx, 32'(imm),         32'(v.imm));
        check("read_head",   idx, 32'(read_head),   32'(v.rh));
        check("queue_level", idx, 32'(queue_level), 32'(v.lvl));
        check("retired",     idx, 32'(retired),     32'(v.ret));
        check("illegal",     idx, 32'(illegal),     32'(v.ill));
    endtask

    task automatic enqueue(input logic [31:0] w);
        queue[{write_head, 5'd0} +: 32] = w;
        write_head = write_head + 2'd1;
    endtask

    initial begin
        vec_t zero_v;
        // do_rst enq word rdy | vld opc dst a b imm | rh lvl ret ill
        // Basic ADD / SETL flow
        vecs.push_back(mk(1,0,32'h0,0,          0,4'h0,4'h0,4'h0,4'h0,16'h0000, 0,0,0,0));
        vecs.push_back(mk(0,1,32'h10000012,1,   1,4'h1,4'h2,4'h1,4'h0,16'h0000, 1,0,0,0));
        vecs.push_back(mk(0,1,32'hB1234000,1,   1,4'hB,4'h0,4'h0,4'h0,16'h1234, 2,0,1,0));
        vecs.push_back(mk(0,0,32'h0,1,          0,4'hB,4'h0,4'h0,4'h0,16'h1234, 2,0,2,0));
        // Back-pressure: fill ring to 3 behind a held instruction, then drain
        vecs.push_back(mk(1,0,32'h0,0,          0,4'h0,4'h0,4'h0,4'h0,16'h0000, 0,0,0,0));
        vecs.push_back(mk(0,1,32'h20000321,0,   1,4'h2,4'h1,4'h2,4'h3,16'h0000, 1,0,0,0));
        vecs.push_back(mk(0,1,32'h30000654,0,   1,4'h2,4'h1,4'h2,4'h3,16'h0000, 1,1,0,0));
        vecs.push_back(mk(0,1,32'hC0000007,0,   1,4'h2,4'h1,4'h2,4'h3,16'h0000, 1,2,0,0));
        vecs.push_back(mk(0,1,32'h40000A98,0,   1,4'h2,4'h1,4'h2,4'h3,16'h0000, 1,3,0,0));
        vecs.push_back(mk(0,0,32'h0,1,          1,4'h3,4'h4,4'h5,4'h6,16'h0000, 2,2,1,0));
        vecs.push_back(mk(0,0,32'h0,1,          1,4'hC,4'h7,4'h0,4'h0,16'h0000, 3,1,2,0));
        vecs.push_back(mk(0,0,32'h0,1,          1,4'h4,4'h8,4'h9,4'hA,16'h0000, 0,0,3,0));
        vecs.push_back(mk(0,0,32'h0,1,          0,4'h4,4'h8,4'h9,4'hA,16'h0000, 0,0,4,0));
        // NOP, reserved opcode, PUSH
        vecs.push_back(mk(0,1,32'h00000000,1,   0,4'h4,4'h8,4'h9,4'hA,16'h0000, 1,0,4,0));
        vecs.push_back(mk(0,1,32'h70000000,1,   0,4'h4,4'h8,4'h9,4'hA,16'h0000, 2,0,4,1));
        vecs.push_back(mk(0,1,32'h80000002,1,   1,4'h8,4'h2,4'h0,4'h0,16'h0000, 3,0,4,1));
        vecs.push_back(mk(0,0,32'h0,1,          0,4'h8,4'h2,4'h0,4'h0,16'h0000, 3,0,5,1));
        // POP with a nonzero must-be-zero bit, from a clean reset
        vecs.push_back(mk(1,0,32'h0,0,          0,4'h0,4'h0,4'h0,4'h0,16'h0000, 0,0,0,0));
        vecs.push_back(mk(0,1,32'h90000010,1,   0,4'h0,4'h0,4'h0,4'h0,16'h0000, 1,0,0,1));
        // NOP waiting behind a held op, consumed on the accepting edge
        vecs.push_back(mk(0,1,32'h10000123,0,   1,4'h1,4'h3,4'h2,4'h1,16'h0000, 2,0,0,1));
        vecs.push_back(mk(0,1,32'h00000000,0,   1,4'h1,4'h3,4'h2,4'h1,16'h0000, 2,1,0,1));
        vecs.push_back(mk(0,0,32'h0,1,          0,4'h1,4'h3,4'h2,4'h1,16'h0000, 3,0,1,1));
        // Set up a held op with two entries queued, ahead of a mid-run reset
        vecs.push_back(mk(0,1,32'h10000012,0,   1,4'h1,4'h2,4'h1,4'h0,16'h0000, 0,0,1,1));
        vecs.push_back(mk(0,1,32'h20000321,0,   1,4'h1,4'h2,4'h1,4'h0,16'h0000, 0,1,1,1));
        vecs.push_back(mk(0,1,32'h30000654,0,   1,4'h1,4'h2,4'h1,4'h0,16'h0000, 0,2,1,1));

        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) begin
                rst_n      = 1'b0;
                op_ready   = 1'b0;
                queue      = '0;
                write_head = 2'd0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                op_ready = vecs[i].rdy;
                if (vecs[i].enq) enqueue(vecs[i].word);
                @(posedge clk);
                #1;
            end
            check_all(i, vecs[i]);
        end

        // Asynchronous reset mid-cycle while an op is held and two entries wait
        #2;
        rst_n      = 1'b0;
        write_head = 2'd0;
        #1;
        zero_v = mk(0,0,32'h0,0, 0,4'h0,4'h0,4'h0,4'h0,16'h0000, 0,0,0,0);
        check_all(100, zero_v);

        // After release the ring is empty; nothing is presented
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        op_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(101, zero_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
